// File: rtl/sensor_ctrl.sv
// sensor_ctrl: collects sensor samples into a word buffer. It raises a level
// interrupt when the buffer is full. The CPU reads the buffer with a
// one-cycle read latency.
module sensor_ctrl #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sctrl_en,
   input  logic          sctrl_clear,
   input  logic [AW-1:0] sctrl_addr,
   output logic [31:0]   sctrl_out,
   output logic          sctrl_interrupt,
   output logic          sensor_en,
   input  logic          sensor_ready,
   input  logic [31:0]   sensor_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic          we;
   logic          sensor_en_q;
   logic          irq_q;
   logic [31:0]   rdata_q;
   logic [31:0]   mem [DEPTH];

   // Next-state, count update and write strobe.
   // A clear takes priority over everything else, so a sample arriving in
   // the same cycle as a clear is dropped.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we      = 1'b0;
      if (sctrl_clear) begin
         state_d = IDLE;
         count_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sctrl_en) state_d = FILL;
            end
            FILL: begin
               if (sensor_ready) begin
                  we      = 1'b1;
                  count_d = count_q + 1'b1;
                  if (count_q == LAST_IDX) state_d = FULL;
                  else if (!sctrl_en)      state_d = IDLE;
               end else if (!sctrl_en) begin
                  state_d = IDLE;
               end
            end
            FULL:    state_d = FULL;
            default: state_d = IDLE;
         endcase
      end
   end

   // State, count and registered outputs.
   // Each output is registered from state_d, so it changes on the same edge
   // as the state it follows.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         sensor_en_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         sensor_en_q <= (state_d == FILL);
         irq_q       <= (state_d == FULL);
      end
   end

   // Sample buffer write port. The buffer contents are not reset.
   always_ff @(posedge clk) begin
      if (we && !rst) mem[count_q[AW-1:0]] <= sensor_out;
   end

   // CPU read port with one cycle of latency.
   // If a write hits the same index in the same cycle, the read returns the
   // old word.
   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= mem[sctrl_addr];
   end

   assign sctrl_out       = rdata_q;
   assign sctrl_interrupt = irq_q;
   assign sensor_en       = sensor_en_q;

endmodule
